// File: rtl/mem_responder.sv
// Wait-state memory responder: takes one read or write request at a time and answers
// WAIT cycles later with a one-cycle mem_ready pulse (err on misaligned or read+write requests).
module mem_responder #(
  parameter int ADDR_W = 8,
  parameter int WAIT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        busy,
  output logic        err
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [3:0]        cnt_r;
  logic [3:0]        cnt_next_s;
  logic [ADDR_W-1:0] idx_r;
  logic [31:0]       wdata_r;
  logic [31:0]       rdata_r;
  logic              op_wr_r;
  logic              op_err_r;
  logic              ready_r;
  logic              busy_r;
  logic              err_r;
  logic              accept_s;
  logic              req_err_s;
  logic              err_next_s;
  logic              unused_s;
  logic [31:0]       mem_r [DEPTH];

  // Address bits above the word index alias onto the same storage.
  assign unused_s  = ^mem_addr[31:ADDR_W+2];
  assign req_err_s = (mem_read & mem_write) | (mem_addr[1:0] != 2'b00);

  assign mem_rdata = rdata_r;
  assign mem_ready = ready_r;
  assign busy      = busy_r;
  assign err       = err_r;

  // Next-state, wait counter and error flag for the upcoming response cycle.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    err_next_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (mem_read | mem_write) begin
          accept_s   = 1'b1;
          cnt_next_s = 4'(WAIT);
          if (WAIT > 0) begin
            state_next_s = BUSY;
          end else begin
            state_next_s = RESP;
            err_next_s   = req_err_s;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        cnt_next_s = cnt_r - 4'd1;
        if (cnt_r <= 4'd1) begin
          state_next_s = RESP;
          err_next_s   = op_err_r;
        end else begin
          state_next_s = BUSY;
        end
      end
      RESP: begin
        state_next_s = IDLE;
        cnt_next_s   = 4'd0;
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // State, request latches and outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      idx_r    <= '0;
      wdata_r  <= 32'h0;
      op_wr_r  <= 1'b0;
      op_err_r <= 1'b0;
      ready_r  <= 1'b0;
      busy_r   <= 1'b0;
      err_r    <= 1'b0;
      rdata_r  <= 32'h0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      ready_r <= (state_next_s == RESP);
      busy_r  <= (state_next_s != IDLE);
      err_r   <= err_next_s;
      if (accept_s) begin
        idx_r    <= mem_addr[ADDR_W+1:2];
        wdata_r  <= mem_wdata;
        op_wr_r  <= mem_write;
        op_err_r <= req_err_s;
      end
      if ((state_r == RESP) && !op_wr_r && !op_err_r) begin
        rdata_r <= mem_r[idx_r];
      end
    end
  end

  // Storage commit; deliberately not reset, and suppressed by a reset in RESP.
  always_ff @(posedge clk) begin
    if (!rst && (state_r == RESP) && op_wr_r && !op_err_r) begin
      mem_r[idx_r] <= wdata_r;
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a WAIT=2 instance under directed and random traffic,
// plus a WAIT=0 instance for the held-level back-to-back pattern.
module tb_mem_responder;
  localparam int WAIT = 2;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr = 32'h0, mem_wdata = 32'h0, mem_rdata;
  logic        mem_read = 1'b0, mem_write = 1'b0, mem_ready, busy, err;
  logic [31:0] rdata0;
  logic        rd0 = 1'b0, ready0, busy0, err0;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  exp_t        sb[$];
  logic [31:0] ref_mem [int];
  logic [31:0] rdata_model = 32'h0;
  logic        rd_pend = 1'b0;
  logic [31:0] rd_pend_val = 32'h0;

  mem_responder #(.ADDR_W(8), .WAIT(WAIT)) u_dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .busy(busy), .err(err)
  );

  mem_responder #(.ADDR_W(8), .WAIT(0)) u_dut0 (
    .clk(clk), .rst(rst), .mem_addr(32'h0), .mem_wdata(32'h0),
    .mem_read(rd0), .mem_write(1'b0), .mem_rdata(rdata0),
    .mem_ready(ready0), .busy(busy0), .err(err0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every response and checks the read data a cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (rd_pend) begin
      check("rdata", mem_rdata, rd_pend_val);
      rd_pend <= 1'b0;
    end
    if (!rst && mem_ready) begin
      if (sb.size() == 0) begin
        check("spurious_ready", 32'(mem_ready), 32'h0);
      end else begin
        e = sb.pop_front();
        check("latency", 32'(cyc), 32'(e.due));
        check("err", 32'(err), 32'(e.err));
        check("busy_in_resp", 32'(busy), 32'h1);
        rd_pend     <= 1'b1;
        rd_pend_val <= e.rdata;
      end
    end else if (err) begin
      check("err_without_ready", 32'(err), 32'h0);
    end
  end

  task automatic wait_idle(output int n_busy);
    int guard;
    n_busy = 0;
    guard  = 0;
    @(negedge clk);
    while (busy !== 1'b0 && guard < 40) begin
      n_busy++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 40) check("idle_timeout", 32'(busy), 32'h0);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic rd, input logic wr);
    exp_t e;
    int   idx;
    int   nb;
    wait_idle(nb);
    idx   = int'((a >> 2) & 32'hFF);
    e.err = (rd & wr) | (a[1:0] != 2'b00);
    if (!e.err && wr) ref_mem[idx] = d;
    else if (!e.err && rd) rdata_model = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    e.rdata   = rdata_model;
    mem_addr  = a;
    mem_wdata = d;
    mem_read  = rd;
    mem_write = wr;
    @(posedge clk);
    #1;
    e.due = cyc + WAIT;
    sb.push_back(e);
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    int          nb;
    int          idx;
    int          op;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(mem_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);
    rst = 1'b0;

    // Basic write/read, busy length, wrap-around and error cases.
    issue(32'h10, 32'hDEADBEEF, 1'b0, 1'b1);
    wait_idle(nb);
    check("busy_cycles", 32'(nb), 32'(WAIT + 1));
    issue(32'h10, 32'h0, 1'b1, 1'b0);
    issue(32'h400, 32'h12345678, 1'b0, 1'b1);
    issue(32'h000, 32'h0, 1'b1, 1'b0);
    issue(32'h13, 32'h0, 1'b1, 1'b0);
    issue(32'h10, 32'h55555555, 1'b1, 1'b1);
    issue(32'h10, 32'h0, 1'b1, 1'b0);

    // Randomised traffic over a pre-written window of words with aliased upper bits.
    for (int i = 16; i < 32; i++) issue(32'(i << 2), $urandom, 1'b0, 1'b1);
    for (int i = 0; i < 60; i++) begin
      idx = $urandom_range(16, 31);
      op  = $urandom_range(0, 9);
      a   = ($urandom & 32'hFFFFFC00) | 32'(idx << 2);
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      if (op < 5) issue(a, 32'h0, 1'b1, 1'b0);
      else if (op < 9) issue(a, $urandom, 1'b0, 1'b1);
      else issue(a, $urandom, 1'b1, 1'b1);
    end

    // Reset while a write waits in BUSY: the write must be discarded.
    issue(32'h20, 32'h0BADF00D, 1'b0, 1'b1);
    wait_idle(nb);
    mem_addr  = 32'h20;
    mem_wdata = 32'hAAAA5555;
    mem_write = 1'b1;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", 32'(mem_ready), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_err", 32'(err), 32'h0);
    check("midrst_rdata", mem_rdata, 32'h0);
    rst = 1'b0;
    rdata_model = 32'h0;
    @(negedge clk);
    check("postrst_ready", 32'(mem_ready), 32'h0);
    check("postrst_busy", 32'(busy), 32'h0);
    check("postrst_rdata", mem_rdata, 32'h0);
    issue(32'h20, 32'h0, 1'b1, 1'b0);
    wait_idle(nb);

    // WAIT=0 instance with the read level held: response every second cycle.
    rd0 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("w0_ready", 32'(ready0), 32'(k % 2));
      check("w0_busy", 32'(busy0), 32'(k % 2));
      check("w0_err", 32'(err0), 32'h0);
    end
    rd0 = 1'b0;

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
